id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/cpu_pkg.sv | 40 ++++
 rtl/hazard_detect.sv | 27 ++
 rtl/id_ex_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath defaults, ALU operation encodings and the
// decoded control bundle carried down the pipeline.
package cpu_pkg;

   localparam int XLEN_DEF = 32;
   localparam int REGW_DEF = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    alu_src;
      alu_op_e alu_op;
   } ctrl_t;

   // A bubble carries this control word: no architectural side effects.
   localparam ctrl_t CTRL_NOP = '{
      reg_write:  1'b0,
      mem_read:   1'b0,
      mem_write:  1'b0,
      mem_to_reg: 1'b0,
      alu_src:    1'b0,
      alu_op:     ALU_ADD
   };

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags a decode instruction that reads the
// destination of a load still sitting in ID/EX. Register 0 never hazards.
module hazard_detect
   import cpu_pkg::*;
#(
   parameter int REGW = REGW_DEF
) (
   input  logic            id_valid,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic            id_ex_valid,
   input  logic            id_ex_mem_read,
   input  logic [REGW-1:0] id_ex_rd,
   output logic            load_use_stall
);

   logic rd_nonzero_s;
   logic src_match_s;

   // Hazard compare on the decode sources against the in-flight load.
   always_comb begin
      rd_nonzero_s   = (id_ex_rd != {REGW{1'b0}});
      src_match_s    = (id_rs1 == id_ex_rd) | (id_rs2 == id_ex_rd);
      load_use_stall = id_valid & id_ex_valid & id_ex_mem_read & rd_nonzero_s & src_match_s;
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and flush handling.
// Optional macro ID_EX_STALL_CNT_EN adds a 32-bit load-use stall counter.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int REGW = REGW_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   output logic            id_ready,
   input  logic [XLEN-1:0] id_pc,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic [REGW-1:0] id_rd,
   input  logic [XLEN-1:0] id_imm,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  ctrl_t           id_ctrl,
   input  logic            ex_ready,
   input  logic            ex_flush,
   output logic            id_ex_valid,
   output logic [XLEN-1:0] id_ex_pc,
   output logic [XLEN-1:0] id_ex_imm,
   output logic [XLEN-1:0] id_ex_rs1_data,
   output logic [XLEN-1:0] id_ex_rs2_data,
   output logic [REGW-1:0] id_ex_rs1,
   output logic [REGW-1:0] id_ex_rs2,
   output logic [REGW-1:0] id_ex_rd,
   output ctrl_t           id_ex_ctrl,
   output logic            load_use_stall
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [31:0]     stall_cnt
`endif
);

   logic            load_use_stall_s;
   logic            load_en_s;
   logic            bubble_en_s;
   logic            valid_r;
   ctrl_t           ctrl_r;
   logic [REGW-1:0] rs1_r;
   logic [REGW-1:0] rs2_r;
   logic [REGW-1:0] rd_r;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] imm_r;
   logic [XLEN-1:0] rs1_data_r;
   logic [XLEN-1:0] rs2_data_r;

   hazard_detect #(.REGW(REGW)) u_hazard_detect (
      .id_valid       (id_valid),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_ex_valid    (valid_r),
      .id_ex_mem_read (ctrl_r.mem_read),
      .id_ex_rd       (rd_r),
      .load_use_stall (load_use_stall_s)
   );

   // Update selection; flush wins over a stalled execute stage and over the hazard.
   always_comb begin
      load_en_s   = ~ex_flush & ex_ready & ~load_use_stall_s & id_valid;
      bubble_en_s = ex_flush | (ex_ready & ~load_en_s);
      id_ready    = ex_flush | (ex_ready & ~load_use_stall_s);
   end

   // Valid, control and register indices: cleared by a bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_r <= 1'b0;
         ctrl_r  <= CTRL_NOP;
         rs1_r   <= {REGW{1'b0}};
         rs2_r   <= {REGW{1'b0}};
         rd_r    <= {REGW{1'b0}};
      end else if (bubble_en_s) begin
         valid_r <= 1'b0;
         ctrl_r  <= CTRL_NOP;
         rs1_r   <= {REGW{1'b0}};
         rs2_r   <= {REGW{1'b0}};
         rd_r    <= {REGW{1'b0}};
      end else if (load_en_s) begin
         valid_r <= 1'b1;
         ctrl_r  <= id_ctrl;
         rs1_r   <= id_rs1;
         rs2_r   <= id_rs2;
         rd_r    <= id_rd;
      end
   end

   // Data payload: only a real capture changes it, bubbles leave it untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_r       <= {XLEN{1'b0}};
         imm_r      <= {XLEN{1'b0}};
         rs1_data_r <= {XLEN{1'b0}};
         rs2_data_r <= {XLEN{1'b0}};
      end else if (load_en_s) begin
         pc_r       <= id_pc;
         imm_r      <= id_imm;
         rs1_data_r <= id_rs1_data;
         rs2_data_r <= id_rs2_data;
      end
   end

`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] stall_cnt_r;

   // Counts edges where the hazard bubble is actually inserted; wraps freely.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_r <= 32'd0;
      end else if (load_use_stall_s & ~ex_flush & ex_ready) begin
         stall_cnt_r <= stall_cnt_r + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_r;
`endif

   assign load_use_stall = load_use_stall_s;
   assign id_ex_valid    = valid_r;
   assign id_ex_ctrl     = ctrl_r;
   assign id_ex_rs1      = rs1_r;
   assign id_ex_rs2      = rs2_r;
   assign id_ex_rd       = rd_r;
   assign id_ex_pc       = pc_r;
   assign id_ex_imm      = imm_r;
   assign id_ex_rs1_data = rs1_data_r;
   assign id_ex_rs2_data = rs2_data_r;

endmodule
